// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device byte transmitter (open-drain clk/data).
// Optional macro PS2_TX_TIMEOUT_EN adds a bus-stall timeout.  Rev 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    FIN       = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    data_q, data_nx;
  logic          parity_q, parity_nx;
  logic [3:0]    bit_cnt, bit_nx;
  logic [IW-1:0] inh_cnt, inh_nx;
  logic          clk_oe_nx, data_oe_nx, busy_nx, done_nx, ack_err_nx;

  // Two-flop synchronizers; a third clock flop gives the falling-edge flag.
  logic clk_meta, clk_sync, clk_sync_d;
  logic data_meta, data_sync;
  logic clk_fall;

  assign clk_fall = clk_sync_d & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt, to_nx;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      clk_sync_d <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk_in;
      clk_sync   <= clk_meta;
      clk_sync_d <= clk_sync;
      data_meta  <= ps2_data_in;
      data_sync  <= data_meta;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_nx;
      data_q      <= data_nx;
      parity_q    <= parity_nx;
      bit_cnt     <= bit_nx;
      inh_cnt     <= inh_nx;
      ps2_clk_oe  <= clk_oe_nx;
      ps2_data_oe <= data_oe_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      ack_err     <= ack_err_nx;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt      <= to_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    data_nx    = data_q;
    parity_nx  = parity_q;
    bit_nx     = bit_cnt;
    inh_nx     = inh_cnt;
    clk_oe_nx  = ps2_clk_oe;
    data_oe_nx = ps2_data_oe;
    busy_nx    = busy;
    ack_err_nx = ack_err;
`ifdef PS2_TX_TIMEOUT_EN
    to_nx      = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nx   = INHIBIT;
          data_nx    = tx_data;
          parity_nx  = ~^tx_data;
          inh_nx     = '0;
          clk_oe_nx  = 1'b1;
          data_oe_nx = 1'b0;
          busy_nx    = 1'b1;
          ack_err_nx = 1'b0;
        end
      end
      INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          state_nx   = REQ;
          data_oe_nx = 1'b1;
        end else begin
          inh_nx = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        state_nx  = SEND;
        clk_oe_nx = 1'b0;
        bit_nx    = '0;
`ifdef PS2_TX_TIMEOUT_EN
        to_nx     = '0;
`endif
      end
      SEND: begin
        if (clk_fall) begin
          bit_nx = bit_cnt + 1'b1;
          if (bit_cnt < 4'd8) begin
            data_oe_nx = ~data_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_nx = ~parity_q;
          end else begin
            data_oe_nx = 1'b0;
            state_nx   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_err_nx = data_sync;
          state_nx   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) state_nx = FIN;
      end
      FIN: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // A stalled device: abandon the frame, free the bus and report an error.
    if (state == SEND || state == ACK || state == WAIT_IDLE) begin
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nx   = FIN;
        clk_oe_nx  = 1'b0;
        data_oe_nx = 1'b0;
        ack_err_nx = 1'b1;
      end else begin
        to_nx = to_cnt + 1'b1;
      end
    end
`endif
    done_nx = (state_nx == FIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// tb_ps2_host_tx : vector table, corner sequences and random frames for
// ps2_host_tx against a PS/2 device model on a wired-AND bus.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  always @(negedge clk) if (done) begin
    done_cnt++;
    done_cyc = cyc;
    done_err = ack_err;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it: bit i = line level after falling edge i+1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      ones += d[i] ? 1 : 0;
    end
    f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic start_xfer(input logic [7:0] d, input bit poke, output bit ok, output int rel_cyc);
    int hi, bfirst, dfirst;
    hi = 0; bfirst = -1; dfirst = -1; ok = 0; rel_cyc = 0;
    @(negedge clk);
    tx_data = d; tx_start = 1'b1;
    for (int k = 0; k < INH + 30; k++) begin
      @(negedge clk);
      if (k == 0) begin tx_start = 1'b0; tx_data = ~d; end
      if (poke && k == 3) begin tx_start = 1'b1; tx_data = 8'h00; end
      if (poke && k == 4) tx_start = 1'b0;
      if (busy && bfirst < 0) bfirst = k;
      if (ps2_data_oe && dfirst < 0) dfirst = k;
      if (ps2_clk_oe) hi++;
      if (busy && !ps2_clk_oe && ps2_data_oe) begin
        ok = 1; rel_cyc = cyc;
        break;
      end
    end
    chk("rts_reached", 32'(ok), 1);
    chk("clk_inhibit_len", hi, INH + 1);
    chk("data_oe_delay", dfirst - bfirst, INH);
  endtask

  task automatic dev_frame(input int n_edges, input bit ack_high, output logic [9:0] bits);
    bits = '0;
    repeat (8) @(negedge clk);
    for (int e = 1; e <= n_edges && e <= 10; e++) begin
      dev_clk = 1'b0; repeat (8) @(negedge clk);
      dev_clk = 1'b1; repeat (8) @(negedge clk);
      bits[e-1] = ps2_data_in;
    end
    if (n_edges >= 11) begin
      dev_data = ack_high; repeat (4) @(negedge clk);
      dev_clk = 1'b0;      repeat (8) @(negedge clk);
      dev_clk = 1'b1;      repeat (4) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input bit ack_high,
                          input logic [9:0] exp_bits, input bit exp_err, input bit poke);
    bit ok;
    int rel, d0;
    logic [9:0] got;
    d0 = done_cnt;
    start_xfer(d, poke, ok, rel);
    if (!ok) return;
    dev_frame(11, ack_high, got);
    for (int k = 0; k < 100 && done_cnt == d0; k++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    chk({tag, "_frame"}, got, exp_bits);
    chk({tag, "_ack_err_at_done"}, done_err, exp_err);
    chk({tag, "_ack_err_held"}, ack_err, exp_err);
    @(negedge clk);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_released"}, {ps2_clk_oe, ps2_data_oe, busy, done}, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack_high;
    logic [9:0] exp_bits;
    bit         exp_err;
  } vec_t;

  vec_t       vecs[6];
  bit         ok;
  int         rel, d0;
  logic [9:0] got;
  logic [7:0] rd;
  bit         ra;

  initial begin
    vecs[0] = '{8'hED, 1'b0, 10'h3ED, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 10'h201, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 10'h300, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 10'h3FF, 1'b1};
    vecs[4] = '{8'h80, 1'b0, 10'h280, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 10'h355, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_err}, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {ps2_clk_oe, ps2_data_oe, busy, done}, 0);

    for (int i = 0; i < 6; i++)
      run_xfer("vec", vecs[i].data, vecs[i].ack_high, vecs[i].exp_bits, vecs[i].exp_err, 1'b0);

    // Back-to-back starts; a start pulsed mid-frame must be ignored.
    run_xfer("b2b_01", 8'h01, 1'b0, 10'h201, 1'b0, 1'b1);
    run_xfer("b2b_00", 8'h00, 1'b0, 10'h300, 1'b0, 1'b0);

    // Reset after edge 5 of a frame: bus freed immediately, no done.
    d0 = done_cnt;
    start_xfer(8'hED, 1'b0, ok, rel);
    if (ok) dev_frame(5, 1'b0, got);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("mid_reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_err}, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_reset_no_done", done_cnt - d0, 0);
    run_xfer("after_reset", 8'h55, 1'b0, 10'h355, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      ra = ($urandom_range(0, 3) == 0);
      run_xfer("rand", rd, ra, model_frame(rd), ra, 1'b0);
    end

    // Device stops clocking after edge 4.
    d0 = done_cnt;
    start_xfer(8'hA5, 1'b0, ok, rel);
    if (ok) dev_frame(4, 1'b0, got);
    for (int k = 0; k < TMO + 200 && done_cnt == d0; k++) @(negedge clk);
`ifdef PS2_TX_TIMEOUT_EN
    chk("timeout_done", done_cnt - d0, 1);
    chk("timeout_latency", done_cyc - rel, TMO);
    chk("timeout_ack_err", done_err, 1);
    @(negedge clk);
    chk("timeout_released", {ps2_clk_oe, ps2_data_oe, busy}, 0);
`else
    chk("stall_no_done", done_cnt - d0, 0);
    chk("stall_busy", busy, 1);
`endif
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("final_idle", {ps2_clk_oe, ps2_data_oe, busy, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
